// File: rtl/asconp_masked_iter.sv
// -----------------------------------------------------------------------------
// asconp_masked_iter
//   Iterative, Boolean-masked (D shares) Ascon-p permutation. One round takes
//   two cycles: RND_A computes the first affine layer plus the round constant
//   and registers the DOM AND partial products; RND_B compresses the DOM
//   terms, finishes chi, applies the second affine layer and the linear
//   diffusion, and writes the shared state register.
//
//   Optional feature: define ASCONP_ZEROIZE_EN to clear the state and DOM
//   registers on the output handshake edge. Without it the last result is
//   held in the state register until the next load.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake; in_ready = (state == IDLE)
//   nr_i                  round count (0 or >12 means 12), sampled on accept
//   x0_i..x4_i            shared input words, share s at [64*s +: 64]
//   rdi / rdi_req         fresh randomness, consumed while rdi_req is high
//   out_valid / out_ready output handshake; out_valid = (state == DONE)
//   x0_o..x4_o            shared state register, same layout as the inputs
//   o_dbg_state           current FSM state (IDLE=0, RND_A=1, RND_B=2, DONE=3)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds its payload while valid is high and ready is
// low. Input and output transfers never share a cycle (IDLE vs DONE).
// -----------------------------------------------------------------------------
module asconp_masked_iter #(
  parameter int D        = 2,
  parameter int RDI_BITS = D * (D - 1) / 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               nr_i,
  input  logic [D*64-1:0]          x0_i,
  input  logic [D*64-1:0]          x1_i,
  input  logic [D*64-1:0]          x2_i,
  input  logic [D*64-1:0]          x3_i,
  input  logic [D*64-1:0]          x4_i,
  input  logic [5*64*RDI_BITS-1:0] rdi,
  output logic                     rdi_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [D*64-1:0]          x0_o,
  output logic [D*64-1:0]          x1_o,
  output logic [D*64-1:0]          x2_o,
  output logic [D*64-1:0]          x3_o,
  output logic [D*64-1:0]          x4_o,
  output logic [1:0]               o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RND_A = 2'd1,
    RND_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  // [word][share][bit]
  typedef logic [4:0][D-1:0][63:0] sh_state_t;
  // [gate][output share p][partial product q][bit]
  typedef logic [4:0][D-1:0][D-1:0][63:0] dom_t;

  state_t    r_state;
  state_t    w_state_nxt;
  sh_state_t r_st;
  sh_state_t r_aff;
  dom_t      r_dom;
  logic [3:0] r_i;
  logic [3:0] r_nr;

  sh_state_t w_aff;
  dom_t      w_dom;
  sh_state_t w_chi;
  sh_state_t w_aff2;
  sh_state_t w_lin;
  logic [3:0] w_nr_eff;
  logic [3:0] w_r;
  logic [7:0] w_rc;
  logic       w_last;

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Index of the randomness word shared by the (a,b) cross terms, a < b.
  function automatic int pair_idx(input int a, input int b);
    return a * D - (a * (a + 1)) / 2 + (b - a - 1);
  endfunction

  assign w_nr_eff = ((nr_i == 4'd0) || (nr_i > 4'd12)) ? 4'd12 : nr_i;
  assign w_r      = 4'd12 - r_nr + r_i;
  assign w_rc     = {4'hF - w_r, w_r};
  assign w_last   = (r_i == (r_nr - 4'd1));

  // First affine layer, share by share; the constant goes into share 0 only.
  always_comb begin
    w_aff = '0;
    for (int s = 0; s < D; s++) begin
      w_aff[0][s] = r_st[0][s] ^ r_st[4][s];
      w_aff[1][s] = r_st[1][s];
      w_aff[2][s] = r_st[2][s] ^ r_st[1][s] ^ ((s == 0) ? {56'd0, w_rc} : 64'd0);
      w_aff[3][s] = r_st[3][s];
      w_aff[4][s] = r_st[4][s] ^ r_st[3][s];
    end
  end

  // DOM AND partial products for gate j: (~a[j+1]) & a[j+2]. Negation of a
  // shared value flips share 0 only. Cross terms are refreshed with one
  // random word per share pair, the same word masking both (p,q) and (q,p).
  always_comb begin
    w_dom = '0;
    for (int j = 0; j < 5; j++) begin
      for (int p = 0; p < D; p++) begin
        for (int q = 0; q < D; q++) begin
          w_dom[j][p][q] = (w_aff[(j + 1) % 5][p] ^ ((p == 0) ? {64{1'b1}} : 64'd0))
                           & w_aff[(j + 2) % 5][q];
          if (p < q) begin
            w_dom[j][p][q] = w_dom[j][p][q] ^ rdi[(j * RDI_BITS + pair_idx(p, q)) * 64 +: 64];
          end else if (p > q) begin
            w_dom[j][p][q] = w_dom[j][p][q] ^ rdi[(j * RDI_BITS + pair_idx(q, p)) * 64 +: 64];
          end
        end
      end
    end
  end

  // DOM compression (registered terms only) and chi completion.
  always_comb begin
    w_chi = '0;
    for (int j = 0; j < 5; j++) begin
      for (int s = 0; s < D; s++) begin
        w_chi[j][s] = r_aff[j][s];
        for (int q = 0; q < D; q++) begin
          w_chi[j][s] = w_chi[j][s] ^ r_dom[j][s][q];
        end
      end
    end
  end

  // Second affine layer and linear diffusion, share by share.
  always_comb begin
    w_aff2 = '0;
    w_lin  = '0;
    for (int s = 0; s < D; s++) begin
      w_aff2[0][s] = w_chi[0][s] ^ w_chi[4][s];
      w_aff2[1][s] = w_chi[1][s] ^ w_chi[0][s];
      w_aff2[2][s] = w_chi[2][s] ^ ((s == 0) ? {64{1'b1}} : 64'd0);
      w_aff2[3][s] = w_chi[3][s] ^ w_chi[2][s];
      w_aff2[4][s] = w_chi[4][s];
      w_lin[0][s] = w_aff2[0][s] ^ ror(w_aff2[0][s], 19) ^ ror(w_aff2[0][s], 28);
      w_lin[1][s] = w_aff2[1][s] ^ ror(w_aff2[1][s], 61) ^ ror(w_aff2[1][s], 39);
      w_lin[2][s] = w_aff2[2][s] ^ ror(w_aff2[2][s], 1)  ^ ror(w_aff2[2][s], 6);
      w_lin[3][s] = w_aff2[3][s] ^ ror(w_aff2[3][s], 10) ^ ror(w_aff2[3][s], 17);
      w_lin[4][s] = w_aff2[4][s] ^ ror(w_aff2[4][s], 7)  ^ ror(w_aff2[4][s], 41);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = RND_A;
      RND_A:   w_state_nxt = RND_B;
      RND_B:   w_state_nxt = w_last ? DONE : RND_A;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_st    <= '0;
      r_aff   <= '0;
      r_dom   <= '0;
      r_i     <= 4'd0;
      r_nr    <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_st[0] <= x0_i;
            r_st[1] <= x1_i;
            r_st[2] <= x2_i;
            r_st[3] <= x3_i;
            r_st[4] <= x4_i;
            r_nr    <= w_nr_eff;
            r_i     <= 4'd0;
          end
        end
        RND_A: begin
          r_aff <= w_aff;
          r_dom <= w_dom;
        end
        RND_B: begin
          r_st <= w_lin;
          if (!w_last) r_i <= r_i + 4'd1;
        end
        DONE: begin
`ifdef ASCONP_ZEROIZE_EN
          if (out_ready) begin
            r_st  <= '0;
            r_aff <= '0;
            r_dom <= '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign rdi_req     = (r_state == RND_A);
  assign o_dbg_state = r_state;
  assign x0_o        = r_st[0];
  assign x1_o        = r_st[1];
  assign x2_o        = r_st[2];
  assign x3_o        = r_st[3];
  assign x4_o        = r_st[4];

endmodule

// File: tb/tb_asconp_masked_iter.sv
// -----------------------------------------------------------------------------
// tb_asconp_masked_iter
//   Two instances (D=2 and D=3) driven in lockstep with the same plaintext,
//   each masked independently. Expected results come from an unmasked
//   reference Ascon-p model and are queued when an input is driven.
// -----------------------------------------------------------------------------
module tb_asconp_masked_iter;

  typedef logic [4:0][63:0] st_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic out_ready;
  logic [3:0] nr_i;

  logic [4:0][127:0] xi2;
  logic [4:0][127:0] xo2;
  logic [319:0]      rdi2;
  logic              in_ready2, out_valid2, rdi_req2;
  logic [1:0]        dbg2;

  logic [4:0][191:0] xi3;
  logic [4:0][191:0] xo3;
  logic [959:0]      rdi3;
  logic              in_ready3, out_valid3, rdi_req3;
  logic [1:0]        dbg3;

  logic [319:0] exp_q[$];
  int           lat_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  asconp_masked_iter #(.D(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .nr_i(nr_i),
    .x0_i(xi2[0]), .x1_i(xi2[1]), .x2_i(xi2[2]), .x3_i(xi2[3]), .x4_i(xi2[4]),
    .rdi(rdi2), .rdi_req(rdi_req2), .out_valid(out_valid2), .out_ready(out_ready),
    .x0_o(xo2[0]), .x1_o(xo2[1]), .x2_o(xo2[2]), .x3_o(xo2[3]), .x4_o(xo2[4]),
    .o_dbg_state(dbg2)
  );

  asconp_masked_iter #(.D(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .nr_i(nr_i),
    .x0_i(xi3[0]), .x1_i(xi3[1]), .x2_i(xi3[2]), .x3_i(xi3[3]), .x4_i(xi3[4]),
    .rdi(rdi3), .rdi_req(rdi_req3), .out_valid(out_valid3), .out_ready(out_ready),
    .x0_o(xo3[0]), .x1_o(xo3[1]), .x2_o(xo3[2]), .x3_o(xo3[3]), .x4_o(xo3[4]),
    .o_dbg_state(dbg3)
  );

  // Fresh randomness every cycle.
  initial begin
    rdi2 = '0;
    rdi3 = '0;
    forever begin
      @(negedge clk);
      for (int w = 0; w < 10; w++) rdi2[w*32 +: 32] = $urandom();
      for (int w = 0; w < 30; w++) rdi3[w*32 +: 32] = $urandom();
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic st_t ascon_p(input st_t s, input int nr);
    st_t x;
    logic [63:0] t [5];
    x = s;
    for (int rr = 12 - nr; rr < 12; rr++) begin
      x[2] = x[2] ^ {56'd0, 8'(((15 - rr) << 4) | rr)};
      x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
      for (int k = 0; k < 5; k++) t[k] = ~x[k] & x[(k + 1) % 5];
      for (int k = 0; k < 5; k++) x[k] ^= t[(k + 1) % 5];
      x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
      x[0] ^= rotr(x[0], 19) ^ rotr(x[0], 28);
      x[1] ^= rotr(x[1], 61) ^ rotr(x[1], 39);
      x[2] ^= rotr(x[2], 1)  ^ rotr(x[2], 6);
      x[3] ^= rotr(x[3], 10) ^ rotr(x[3], 17);
      x[4] ^= rotr(x[4], 7)  ^ rotr(x[4], 41);
    end
    return x;
  endfunction

  function automatic st_t rec2(input logic [4:0][127:0] v);
    st_t r;
    for (int k = 0; k < 5; k++) r[k] = v[k][63:0] ^ v[k][127:64];
    return r;
  endfunction

  function automatic st_t rec3(input logic [4:0][191:0] v);
    st_t r;
    for (int k = 0; k < 5; k++) r[k] = v[k][63:0] ^ v[k][127:64] ^ v[k][191:128];
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- checkers ----------------
  task automatic check_w(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic start_op(input st_t p, input logic [3:0] nr, input bit masked);
    logic [63:0] m1, m2;
    int eff;
    for (int k = 0; k < 5; k++) begin
      m1 = masked ? rnd64() : 64'd0;
      m2 = masked ? rnd64() : 64'd0;
      xi2[k] = {m1, p[k] ^ m1};
      xi3[k] = {m2, m1, p[k] ^ m1 ^ m2};
    end
    eff = ((nr == 4'd0) || (nr > 4'd12)) ? 12 : int'(nr);
    check_i("in_ready_pre", int'(in_ready3) + int'(in_ready2), 2);
    nr_i     = nr;
    in_valid = 1'b1;
    exp_q.push_back(ascon_p(p, eff));
    lat_q.push_back(2 * eff);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      xi2[k] = {rnd64(), rnd64()};
      xi3[k] = {rnd64(), rnd64(), rnd64()};
    end
  endtask

  task automatic finish_op(input string tag, input int hold);
    int lat, nreq, exp_lat;
    logic [319:0] exp;
    lat  = 0;
    nreq = 0;
    while (out_valid3 !== 1'b1 && lat < 200) begin
      nreq += int'(rdi_req3);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    exp     = exp_q.pop_front();
    exp_lat = lat_q.pop_front();
    check_i({tag, "_lat"}, lat, exp_lat);
    check_i({tag, "_rdireq_cycles"}, nreq, exp_lat / 2);
    check_i({tag, "_ov2"}, int'(out_valid2), 1);
    check_i({tag, "_dbg_done"}, int'(dbg3), 3);
    check_w({tag, "_res_d2"}, rec2(xo2), exp);
    check_w({tag, "_res_d3"}, rec3(xo3), exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check_w({tag, "_hold_res"}, rec3(xo3), exp);
      check_i({tag, "_hold_ir_ov"}, int'(in_ready3) * 2 + int'(out_valid3), 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_i({tag, "_post_ir"}, int'(in_ready3) + int'(in_ready2), 2);
    check_i({tag, "_post_ov"}, int'(out_valid3) + int'(out_valid2), 0);
`ifdef ASCONP_ZEROIZE_EN
    check_i({tag, "_post_zero"}, int'((|xo3) | (|xo2)), 0);
`else
    check_w({tag, "_post_held_d2"}, rec2(xo2), exp);
    check_w({tag, "_post_held_d3"}, rec3(xo3), exp);
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    st_t p;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    nr_i      = 4'd0;
    xi2       = '0;
    xi3       = '0;
    repeat (2) @(negedge clk);

    // Reset values while reset is held.
    check_i("rst_in_ready", int'(in_ready2) + int'(in_ready3), 2);
    check_i("rst_out_valid", int'(out_valid2) + int'(out_valid3), 0);
    check_i("rst_rdi_req", int'(rdi_req2) + int'(rdi_req3), 0);
    check_i("rst_x_zero", int'((|xo2) | (|xo3)), 0);
    check_i("rst_dbg", int'(dbg2) + int'(dbg3), 0);
    rst = 1'b0;
    @(negedge clk);

    // All-zero state, unmasked shares, p12.
    p = '0;
    start_op(p, 4'd12, 1'b0);
    finish_op("zero_p12", 0);

    // Random plaintext, masked, p6 / p8 / p0->p12.
    p = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
    start_op(p, 4'd6, 1'b1);
    finish_op("p6", 0);
    start_op(p, 4'd8, 1'b1);
    finish_op("p8", 0);
    start_op(p, 4'd0, 1'b1);
    finish_op("p0_as_12", 0);

    // Round-count boundaries.
    p = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
    start_op(p, 4'd1, 1'b1);
    finish_op("p1", 0);
    start_op(p, 4'd14, 1'b1);
    finish_op("p14_as_12", 0);

    // Output back-pressure for 5 cycles.
    p = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
    start_op(p, 4'd4, 1'b1);
    finish_op("hold5", 5);

    // Reset 7 cycles into a p12 run.
    p = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
    start_op(p, 4'd12, 1'b1);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_i("abort_ov", int'(out_valid2) + int'(out_valid3), 0);
    check_i("abort_ir", int'(in_ready2) + int'(in_ready3), 2);
    check_i("abort_x_zero", int'((|xo2) | (|xo3)), 0);
    @(negedge clk);
    check_i("abort_x_zero_held", int'((|xo2) | (|xo3)), 0);
    rst = 1'b0;
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    @(negedge clk);
    check_i("abort_after_release", int'((|xo2) | (|xo3) | out_valid3), 0);

    // Fresh run after the abort.
    p = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
    start_op(p, 4'd12, 1'b1);
    finish_op("post_abort_p12", 0);

    check_i("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/asconp_masked_iter.md
ASCONP_MASKED_ITER -- requirements
Module: asconp_masked_iter

Interface
REQ-001 Parameter D, default 2, SHALL set the number of Boolean shares; legal values are 2 to 4.
REQ-002 Parameter RDI_BITS, default D*(D-1)/2, SHALL set the fresh-randomness bits per DOM AND gate per bit lane.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 in_valid  input  1  SHALL qualify the input state and nr_i.
REQ-006 in_ready  output  1  SHALL indicate that a new state can be accepted.
REQ-007 nr_i  input  4  SHALL give the round count, sampled on acceptance.
REQ-008 x0_i..x4_i  input  D*64 each  SHALL carry the shared input state words; share s occupies bits [64*s +: 64].
REQ-009 rdi  input  5*64*RDI_BITS  SHALL carry fresh randomness for the five 64-bit DOM AND layers.
REQ-010 rdi_req  output  1  SHALL be high in every cycle in which rdi is consumed.
REQ-011 out_valid  output  1  SHALL indicate that x0_o..x4_o hold the permuted state.
REQ-012 out_ready  input  1  SHALL accept the output.
REQ-013 x0_o..x4_o  output  D*64 each  SHALL carry the shared state register, in the same share layout as the inputs.

Function
REQ-014 The FSM SHALL have four states: IDLE, RND_A, RND_B and DONE.
REQ-015 in_ready SHALL equal (state==IDLE), and out_valid SHALL equal (state==DONE).
REQ-016 In IDLE with in_valid high, the block SHALL load all shares into the state register, latch nr, clear the round index i, and enter RND_A.
REQ-017 An nr_i of 0 or greater than 12 SHALL be treated as 12.
REQ-018 RND_A SHALL perform the first affine layer and the round constant, feed the masked chi operands into registered DOM AND gates, assert rdi_req, and go to RND_B.
REQ-019 RND_B SHALL complete chi, the second affine layer and the linear diffusion from the DOM outputs and the held aff1 values, then write the state register.
REQ-020 From RND_B, the FSM SHALL increment i and go to RND_A if i < nr-1, or go to DONE otherwise.
REQ-021 The round constant SHALL use r = 12 - nr + i, take the byte {4'hF - r, r[3:0]}, and XOR it into bits [7:0] of x2 share 0 only.
REQ-022 Chi SHALL apply the NOT to share 0 only, so that XOR-recombining the shares yields the unmasked Ascon-p result.
REQ-023 Latency SHALL be exactly 2*nr cycles from the accepting edge to the first cycle with out_valid high.
REQ-024 In DONE, the outputs SHALL stay stable while out_ready is low; with out_ready high the FSM SHALL return to IDLE.
REQ-025 A new input SHALL NOT be accepted in the same cycle as the output handshake.
REQ-026 in_valid SHALL be ignored outside IDLE, and rdi SHALL be ignored outside RND_A.
REQ-027 Shares SHALL never be combined in any register or combinational path other than inside the DOM AND gates.

Reset
REQ-028 On rst, the block SHALL immediately enter IDLE, zero the state register, the DOM registers, i and nr, and drive in_ready=1, out_valid=0, rdi_req=0 and x*_o=0.
REQ-029 A reset during RND_A, RND_B or DONE SHALL abort the operation, with no partial result visible after reset is released.

Configuration
REQ-030 With macro ASCONP_ZEROIZE_EN defined, the state register and DOM registers SHALL be cleared to zero on the output handshake edge, so that x*_o reads 0 in IDLE.
REQ-031 Without ASCONP_ZEROIZE_EN, the state register SHALL retain the last result in IDLE until the next load.

Verification
REQ-032 D=2, share0=0, share1=0, nr_i=12, rdi random -> out_valid rises 24 cycles after acceptance, and the XOR of the shares equals the software Ascon-p12 of the all-zero state.
REQ-033 D=3 with the same plaintext state split by random masks, and nr_i=6, 8 and 0 in turn -> latencies of 12, 16 and 24 cycles, each recombined result matching the model for p6, p8 and p12.
REQ-034 out_ready held low for 5 cycles in DONE -> outputs constant and in_ready=0; out_ready=1 -> in_ready=1 on the next cycle.
REQ-035 rst asserted 7 cycles after acceptance with nr=12 -> out_valid=0, in_ready=1 and x*_o=0 while reset is held; after release, a fresh run completes correctly.
REQ-036 With ASCONP_ZEROIZE_EN -> x*_o=0 the cycle after the handshake; without it -> the result is held.
